// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with break-code tracking and frame timeout
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_next;
    logic          clk_meta, clk_sync, clk_prev;
    logic          data_meta, data_sync;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          break_pending;
    logic [TW-1:0] tcnt;

    logic fall, timeout_hit;
    logic start_frame, shift_en, cap_parity, frame_done, frame_good;

    assign fall        = clk_prev & ~clk_sync;
    assign timeout_hit = (tcnt == TMAX);
    // Odd parity across data+parity, and the stop bit sampled on this edge must be 1.
    assign frame_good  = data_sync & (^{shift_reg, parity_bit});

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        cap_parity  = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_sync) begin
                    state_next  = DATA;
                    start_frame = 1'b1;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_next = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    cap_parity = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // An edge arriving in the timeout cycle takes priority over the abort.
        if (!fall && state != IDLE && timeout_hit) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            state     <= state_next;
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            tcnt       <= '0;
        end else begin
            if (fall || state == IDLE) tcnt <= '0;
            else if (!timeout_hit)     tcnt <= tcnt + 1'b1;

            if (start_frame) begin
                bit_cnt   <= 3'd0;
                shift_reg <= 8'h00;
            end else if (shift_en) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= {data_sync, shift_reg[7:1]};
            end else if (!fall && state != IDLE && timeout_hit) begin
                bit_cnt   <= 3'd0;
                shift_reg <= 8'h00;
            end

            if (cap_parity) parity_bit <= data_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            code          <= 8'h00;
            code_valid    <= 1'b0;
            is_break      <= 1'b0;
            frame_err     <= 1'b0;
            break_pending <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (frame_done) begin
                if (!frame_good) begin
                    frame_err     <= 1'b1;
                    break_pending <= 1'b0;
                end else if (shift_reg == 8'hF0) begin
                    break_pending <= 1'b1;
                end else if (shift_reg != 8'hE0) begin
                    code          <= shift_reg;
                    is_break      <= break_pending;
                    break_pending <= 1'b0;
                    frame_err     <= 1'b0;
                    code_valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - table-driven self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int pulse_total = 0;
    int p0;

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk),
        .clr(clr),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .code(code),
        .code_valid(code_valid),
        .is_break(is_break),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (code_valid) pulse_total <= pulse_total + 1;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         stop;
        int         hw;
        int         exp_pulses;
        logic [7:0] exp_code;
        bit         exp_brk;
        bit         exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int hw);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(hw);
            ps2_clk = 1'b0;
            wait_cyc(hw);
            ps2_clk = 1'b1;
        end
    endtask

    initial begin
        logic [10:0] f;

        vecs[0]  = '{8'h1C, 0, 1, 8, 1, 8'h1C, 0, 0};
        vecs[1]  = '{8'hF0, 0, 1, 8, 0, 8'h1C, 0, 0};
        vecs[2]  = '{8'h1C, 0, 1, 8, 1, 8'h1C, 1, 0};
        vecs[3]  = '{8'h1C, 0, 1, 8, 1, 8'h1C, 0, 0};
        vecs[4]  = '{8'h1C, 1, 1, 8, 0, 8'h1C, 0, 1};
        vecs[5]  = '{8'h32, 0, 1, 8, 1, 8'h32, 0, 0};
        vecs[6]  = '{8'hE0, 0, 1, 3, 0, 8'h32, 0, 0};
        vecs[7]  = '{8'hF0, 0, 1, 3, 0, 8'h32, 0, 0};
        vecs[8]  = '{8'h74, 0, 1, 3, 1, 8'h74, 1, 0};
        vecs[9]  = '{8'h55, 0, 0, 8, 0, 8'h74, 1, 1};
        vecs[10] = '{8'hF0, 0, 1, 8, 0, 8'h74, 1, 1};
        vecs[11] = '{8'h1C, 1, 1, 8, 0, 8'h74, 1, 1};
        vecs[12] = '{8'h1C, 0, 1, 8, 1, 8'h1C, 0, 0};
        vecs[13] = '{8'hA5, 0, 1, 3, 1, 8'hA5, 0, 0};

        wait_cyc(3);
        clr = 1'b0;
        check("reset_code", {24'd0, code}, 32'h00);
        check("reset_valid", {31'd0, code_valid}, 0);
        check("reset_brk", {31'd0, is_break}, 0);
        check("reset_err", {31'd0, frame_err}, 0);

        // Stop-bit latency: two synchronizer flops, one edge-detect cycle, then the registered pulse.
        send_bits(frame_bits(8'h1C, 0, 1), 10, 8);
        ps2_data = 1'b1;
        wait_cyc(8);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_before", {31'd0, code_valid}, 0);
        @(negedge clk);
        check("lat_pulse", {31'd0, code_valid}, 1);
        check("lat_code", {24'd0, code}, 32'h1C);
        @(negedge clk);
        check("lat_after", {31'd0, code_valid}, 0);
        wait_cyc(4);
        ps2_clk = 1'b1;
        wait_cyc(8);

        for (int i = 0; i < 14; i++) begin
            p0 = pulse_total;
            send_bits(frame_bits(vecs[i].data, vecs[i].bad_par, vecs[i].stop), 11, vecs[i].hw);
            wait_cyc(10);
            check($sformatf("vec%0d_pulses", i), pulse_total - p0, vecs[i].exp_pulses);
            check($sformatf("vec%0d_code", i), {24'd0, code}, {24'd0, vecs[i].exp_code});
            check($sformatf("vec%0d_brk", i), {31'd0, is_break}, {31'd0, vecs[i].exp_brk});
            check($sformatf("vec%0d_err", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_err});
        end

        // Partial frame abandoned past the timeout, then a clean frame.
        p0 = pulse_total;
        send_bits(frame_bits(8'hFF, 0, 1), 5, 8);
        wait_cyc(150);
        check("to_no_pulse", pulse_total - p0, 0);
        check("to_err_kept", {31'd0, frame_err}, 0);
        send_bits(frame_bits(8'h2A, 0, 1), 11, 8);
        wait_cyc(10);
        check("to_pulses", pulse_total - p0, 1);
        check("to_code", {24'd0, code}, 32'h2A);

        // A gap shorter than the timeout must not break the frame.
        p0 = pulse_total;
        f = frame_bits(8'h66, 0, 1);
        send_bits(f, 5, 8);
        wait_cyc(60);
        send_bits(f >> 5, 6, 8);
        wait_cyc(10);
        check("gap_pulses", pulse_total - p0, 1);
        check("gap_code", {24'd0, code}, 32'h66);

        // Mid-frame clr after a rejected frame.
        send_bits(frame_bits(8'h77, 1, 1), 11, 8);
        wait_cyc(10);
        check("pre_clr_err", {31'd0, frame_err}, 1);
        send_bits(frame_bits(8'h45, 0, 1), 5, 8);
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
        check("clr_code", {24'd0, code}, 32'h00);
        check("clr_valid", {31'd0, code_valid}, 0);
        check("clr_brk", {31'd0, is_break}, 0);
        check("clr_err", {31'd0, frame_err}, 0);
        p0 = pulse_total;
        send_bits(frame_bits(8'h45, 0, 1), 11, 8);
        wait_cyc(10);
        check("post_clr_pulses", pulse_total - p0, 1);
        check("post_clr_code", {24'd0, code}, 32'h45);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 50000, meaning the number of clk cycles without a PS/2 falling edge after which a partial frame is aborted.
REQ-002 SHALL provide port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL provide port clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-005 SHALL provide port ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-006 SHALL provide port code  output  8  last accepted scan code, held until the next accepted code; feeds the two-digit hex display.
REQ-007 SHALL provide port code_valid  output  1  one-cycle pulse marking a newly accepted code.
REQ-008 SHALL provide port is_break  output  1  1 when the held code is a key release (preceded by 0xF0).
REQ-009 SHALL provide port frame_err  output  1  sticky flag for a parity or stop-bit failure.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-011 SHALL detect a falling edge when the previous synchronized ps2_clk is 1 and the current one is 0; sample synchronized ps2_data in that same cycle.
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: on edge with data 0 (start bit), go to DATA and clear the bit counter. On edge with data 1, stay in IDLE with no other effect.
REQ-014 DATA: shift in one bit per edge, LSB first. After the 8th bit, go to PARITY.
REQ-015 PARITY: capture the bit and go to STOP. Parity is good when the 8 data bits plus the parity bit hold an odd number of ones.
REQ-016 STOP: on the next edge, return to IDLE. The frame is accepted only if the stop bit is 1 and parity is good.
REQ-017 Rejected frame: set frame_err. code, is_break and code_valid stay unchanged, and break_pending is cleared.
REQ-018 Accepted byte 0xF0: set internal break_pending. No code_valid.
REQ-019 Accepted byte 0xE0: discard. No code_valid, and break_pending is unchanged.
REQ-020 Any other accepted byte:
  - code <= byte
  - is_break <= break_pending
  - break_pending <= 0
  - frame_err <= 0
  - code_valid = 1 for exactly one cycle
REQ-021 Latency: code and is_break update, and code_valid is high, in the clk cycle immediately after the cycle in which the stop-bit edge is detected.
REQ-022 Timeout counter:
  - clears on every detected falling edge and in IDLE
  - increments otherwise
  - saturates at TIMEOUT_CYCLES
  - its width is sufficient for TIMEOUT_CYCLES
REQ-023 When the counter reaches TIMEOUT_CYCLES outside IDLE: return to IDLE, discard partial bits, leave frame_err and break_pending unchanged, and assert no code_valid.
REQ-024 If a falling edge and the timeout occur in the same cycle, the edge SHALL win and the counter clears.
REQ-025 A frame starting in the cycle after code_valid SHALL be received normally; there is no dead time beyond STOP->IDLE.

Reset
REQ-026 While clr=1 at a rising clk edge:
  - state = IDLE, bit counter = 0, shift register = 0, timeout counter = 0
  - break_pending = 0
  - synchronizer and edge-detect flops = 1 (idle bus)
  - code = 8'h00, code_valid = 0, is_break = 0, frame_err = 0
REQ-027 clr asserted mid-frame SHALL abort the frame. The first falling edge after clr deasserts SHALL be treated as a potential start bit.

Verification
REQ-028 Frame 0x1C (parity 0, stop 1) -> code=8'h1C, is_break=0, code_valid high for exactly 1 cycle, one cycle after the stop edge.
REQ-029 Frames 0xF0 then 0x1C -> no pulse for 0xF0; then code=8'h1C, is_break=1, single pulse. A following 0x1C -> is_break=0.
REQ-030 Frame 0x1C with parity 1 -> frame_err=1, code unchanged, no pulse. Next good frame 0x32 -> frame_err=0, code=8'h32.
REQ-031 Stop 4 data bits of a frame and idle for TIMEOUT_CYCLES (set to 100 for the bench) -> state IDLE, no pulse. A full 0x2A frame then -> code=8'h2A.
REQ-032 Assert clr for 1 cycle after the 5th bit -> all outputs at reset values. A full 0x45 frame afterwards -> code=8'h45, one pulse.
REQ-033 Frames 0xE0, 0xF0, 0x74 -> a single pulse with code=8'h74, is_break=1. Glitch-free ps2_clk pulse widths of 3 clk cycles -> still decoded correctly.
